// File: rtl/can_tx_scheduler.sv
// rtl/can_tx_scheduler.sv - round-robin Wishbone sequencer sharing one CAN TX/RX register shell
module can_tx_scheduler #(
  parameter int NREQ     = 4,
  parameter bit LOOPBACK = 1'b1,
  parameter int POLL_MAX = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [11*NREQ-1:0]   req_id,
  input  logic [8*NREQ-1:0]    req_len,
  input  logic [8*NREQ-1:0]    req_d0,
  input  logic [8*NREQ-1:0]    req_d1,
  output logic [NREQ-1:0]      req_ack,
  output logic [NREQ-1:0]      req_err,
  output logic                 busy,
  output logic [2:0]           grant_idx,
  output logic                 rx_valid,
  output logic [10:0]          rx_id,
  output logic [7:0]           rx_len,
  output logic [7:0]           rx_d0,
  output logic [7:0]           rx_d1,
  output logic [31:0]          wb_adr_o,
  output logic [31:0]          wb_dat_o,
  input  logic [31:0]          wb_dat_i,
  output logic                 wb_we_o,
  output logic                 wb_cyc_o,
  output logic                 wb_stb_o,
  input  logic                 wb_ack_i
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_ID, S_WR_LEN, S_WR_D0, S_WR_D1, S_WR_CMD, S_POLL,
    S_RD_RID, S_RD_RLEN, S_RD_RD0, S_RD_RD1, S_CLR, S_DONE
  } state_t;

  state_t          state_q;
  logic [2:0]      rr_ptr_q, grant_q;
  logic [7:0]      poll_cnt_q;
  logic [10:0]     id_q;
  logic [7:0]      len_q, d0_q, d1_q;
  logic [2:0]      w1c_q;
  logic            timeout_q, rx_got_q, busy_q, act_q, we_q, rx_valid_q;
  logic [31:0]     adr_q, dat_q;
  logic [NREQ-1:0] req_ack_q, req_err_q;
  logic [10:0]     rx_id_q;
  logic [7:0]      rx_len_q, rx_d0_q, rx_d1_q;

  logic            hi_found, lo_found;
  logic [2:0]      hi_idx, lo_idx, win_idx, rr_next;
  logic [10:0]     sel_id;
  logic [7:0]      sel_len, sel_d0, sel_d1, len_clamp;
  logic [NREQ-1:0] grant_oh;
  logic            op_we_d;
  logic [31:0]     op_adr_d, op_dat_d;
  logic            unused_dat;

  assign unused_dat = ^wb_dat_i[31:11];

  // Descending scans leave the lowest index set; "hi" only counts indices at/after rr_ptr.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = 3'd0;
    lo_found = 1'b0;
    lo_idx   = 3'd0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_found = 1'b1;
        lo_idx   = 3'(i);
        if (3'(i) >= rr_ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = 3'(i);
        end
      end
    end
    win_idx = hi_found ? hi_idx : lo_idx;
    rr_next = (win_idx == 3'(NREQ - 1)) ? 3'd0 : win_idx + 3'd1;
  end

  always_comb begin
    sel_id  = '0;
    sel_len = '0;
    sel_d0  = '0;
    sel_d1  = '0;
    for (int i = 0; i < NREQ; i++) begin
      grant_oh[i] = (3'(i) == grant_q);
      if (3'(i) == win_idx) begin
        sel_id  = req_id[11*i +: 11];
        sel_len = req_len[8*i +: 8];
        sel_d0  = req_d0[8*i +: 8];
        sel_d1  = req_d1[8*i +: 8];
      end
    end
  end

  assign len_clamp = (len_q > 8'd8) ? 8'd8 : len_q;

  always_comb begin
    op_we_d  = 1'b0;
    op_adr_d = 32'h0;
    op_dat_d = 32'h0;
    case (state_q)
      S_WR_ID:   begin op_we_d = 1'b1; op_adr_d = 32'h08; op_dat_d = {21'h0, id_q}; end
      S_WR_LEN:  begin op_we_d = 1'b1; op_adr_d = 32'h0C; op_dat_d = {24'h0, len_clamp}; end
      S_WR_D0:   begin op_we_d = 1'b1; op_adr_d = 32'h10; op_dat_d = {24'h0, d0_q}; end
      S_WR_D1:   begin op_we_d = 1'b1; op_adr_d = 32'h14; op_dat_d = {24'h0, d1_q}; end
      S_WR_CMD:  begin op_we_d = 1'b1; op_adr_d = 32'h00; op_dat_d = {30'h0, LOOPBACK, 1'b1}; end
      S_POLL:    op_adr_d = 32'h04;
      S_RD_RID:  op_adr_d = 32'h18;
      S_RD_RLEN: op_adr_d = 32'h1C;
      S_RD_RD0:  op_adr_d = 32'h20;
      S_RD_RD1:  op_adr_d = 32'h24;
      S_CLR:     begin op_we_d = 1'b1; op_adr_d = 32'h04; op_dat_d = {29'h0, w1c_q}; end
      default:   op_we_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      poll_cnt_q <= '0;
      id_q       <= '0;
      len_q      <= '0;
      d0_q       <= '0;
      d1_q       <= '0;
      w1c_q      <= '0;
      timeout_q  <= 1'b0;
      rx_got_q   <= 1'b0;
      busy_q     <= 1'b0;
      act_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      req_ack_q  <= '0;
      req_err_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_id_q    <= '0;
      rx_len_q   <= '0;
      rx_d0_q    <= '0;
      rx_d1_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (lo_found) begin
            grant_q    <= win_idx;
            rr_ptr_q   <= rr_next;
            id_q       <= sel_id;
            len_q      <= sel_len;
            d0_q       <= sel_d0;
            d1_q       <= sel_d1;
            poll_cnt_q <= '0;
            timeout_q  <= 1'b0;
            rx_got_q   <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_WR_ID;
          end
        end
        S_DONE: begin
          req_ack_q  <= '0;
          req_err_q  <= '0;
          rx_valid_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: begin
          // The cycle with the bus idle on entry to each op state is the mandatory gap.
          if (!act_q) begin
            act_q <= 1'b1;
            we_q  <= op_we_d;
            adr_q <= op_adr_d;
            dat_q <= op_dat_d;
          end else if (wb_ack_i) begin
            act_q <= 1'b0;
            we_q  <= 1'b0;
            adr_q <= '0;
            dat_q <= '0;
            case (state_q)
              S_WR_ID:  state_q <= S_WR_LEN;
              S_WR_LEN: state_q <= S_WR_D0;
              S_WR_D0:  state_q <= S_WR_D1;
              S_WR_D1:  state_q <= S_WR_CMD;
              S_WR_CMD: state_q <= S_POLL;
              S_POLL: begin
                if (!wb_dat_i[0]) begin
                  if (poll_cnt_q + 8'd1 == 8'(POLL_MAX)) begin
                    w1c_q     <= 3'h7;
                    timeout_q <= 1'b1;
                    state_q   <= S_CLR;
                  end else begin
                    poll_cnt_q <= poll_cnt_q + 8'd1;
                  end
                end else if (wb_dat_i[1]) begin
                  state_q <= S_RD_RID;
                end else begin
                  w1c_q   <= 3'h1;
                  state_q <= S_CLR;
                end
              end
              S_RD_RID:  begin rx_id_q  <= wb_dat_i[10:0]; state_q <= S_RD_RLEN; end
              S_RD_RLEN: begin rx_len_q <= wb_dat_i[7:0];  state_q <= S_RD_RD0; end
              S_RD_RD0:  begin rx_d0_q  <= wb_dat_i[7:0];  state_q <= S_RD_RD1; end
              S_RD_RD1: begin
                rx_d1_q  <= wb_dat_i[7:0];
                rx_got_q <= 1'b1;
                w1c_q    <= 3'h3;
                state_q  <= S_CLR;
              end
              S_CLR: begin
                if (timeout_q) req_err_q <= grant_oh;
                else           req_ack_q <= grant_oh;
                rx_valid_q <= rx_got_q;
                state_q    <= S_DONE;
              end
              default: state_q <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign req_ack   = req_ack_q;
  assign req_err   = req_err_q;
  assign busy      = busy_q;
  assign grant_idx = grant_q;
  assign rx_valid  = rx_valid_q;
  assign rx_id     = rx_id_q;
  assign rx_len    = rx_len_q;
  assign rx_d0     = rx_d0_q;
  assign rx_d1     = rx_d1_q;
  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;
  assign wb_we_o   = we_q;
  assign wb_cyc_o  = act_q;
  assign wb_stb_o  = act_q;

endmodule

// File: tb/tb_can_tx_scheduler.sv
// tb/tb_can_tx_scheduler.sv - scoreboard bench for can_tx_scheduler against a CAN register-shell model
module tb_can_tx_scheduler;

  localparam int NREQ  = 4;
  localparam bit LB    = 1'b1;
  localparam int PMAX  = 3;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } op_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [11*NREQ-1:0] req_id = '0;
  logic [8*NREQ-1:0] req_len = '0, req_d0 = '0, req_d1 = '0;
  logic [NREQ-1:0]   req_ack, req_err;
  logic              busy, rx_valid;
  logic [2:0]        grant_idx;
  logic [10:0]       rx_id;
  logic [7:0]        rx_len, rx_d0, rx_d1;
  logic [31:0]       wb_adr_o, wb_dat_o, wb_dat_i;
  logic              wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i;

  int  checks = 0;
  int  errors = 0;
  int  cyc_cnt = 0;
  op_t exp_q[$];

  // Controller model
  logic        ack_q = 1'b0;
  logic [2:0]  s_st = '0;
  logic [10:0] s_txid = '0, s_rid = '0;
  logic [7:0]  s_txlen = '0, s_txd0 = '0, s_txd1 = '0, s_rlen = '0, s_rd0 = '0, s_rd1 = '0;
  logic [31:0] s_rdata;
  bit          mode_norx = 0, mode_nodone = 0;

  can_tx_scheduler #(.NREQ(NREQ), .LOOPBACK(LB), .POLL_MAX(PMAX)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_id(req_id), .req_len(req_len),
    .req_d0(req_d0), .req_d1(req_d1), .req_ack(req_ack), .req_err(req_err), .busy(busy),
    .grant_idx(grant_idx), .rx_valid(rx_valid), .rx_id(rx_id), .rx_len(rx_len),
    .rx_d0(rx_d0), .rx_d1(rx_d1), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_ack_i(wb_ack_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  assign wb_ack_i = ack_q;

  always @(posedge clk) begin
    ack_q <= wb_cyc_o && wb_stb_o && !ack_q;
    if (wb_cyc_o && wb_stb_o && ack_q && wb_we_o) begin
      case (wb_adr_o)
        32'h00: if (wb_dat_o[0] && !mode_nodone) begin
          s_st[0] <= 1'b1;
          if (wb_dat_o[1] && !mode_norx) begin
            s_st[1] <= 1'b1;
            s_rid <= s_txid; s_rlen <= s_txlen; s_rd0 <= s_txd0; s_rd1 <= s_txd1;
          end
        end
        32'h04: s_st <= s_st & ~wb_dat_o[2:0];
        32'h08: s_txid  <= wb_dat_o[10:0];
        32'h0C: s_txlen <= wb_dat_o[7:0];
        32'h10: s_txd0  <= wb_dat_o[7:0];
        32'h14: s_txd1  <= wb_dat_o[7:0];
        default: ;
      endcase
    end
  end

  // Upper bits are junk so the DUT's field slicing is exercised.
  always_comb begin
    case (wb_adr_o)
      32'h04:  s_rdata = {29'h0, s_st};
      32'h18:  s_rdata = {21'h1FFFFF, s_rid};
      32'h1C:  s_rdata = {24'hEE0000, s_rlen};
      32'h20:  s_rdata = {24'hDD0000, s_rd0};
      32'h24:  s_rdata = {24'hCC0000, s_rd1};
      default: s_rdata = 32'h0;
    endcase
  end
  assign wb_dat_i = s_rdata;

  wire [120:0] all_out = {req_ack, req_err, busy, grant_idx, rx_valid, rx_id, rx_len, rx_d0,
                          rx_d1, wb_adr_o, wb_dat_o, wb_we_o, wb_cyc_o, wb_stb_o};

  task automatic push_op(input logic we, input logic [31:0] adr, input logic [31:0] dat);
    op_t o;
    o.we = we; o.adr = adr; o.dat = dat;
    exp_q.push_back(o);
  endtask

  task automatic push_txn(input logic [10:0] id, input logic [7:0] len, input logic [7:0] d0,
                          input logic [7:0] d1, input bit rx, input bit tmo);
    push_op(1'b1, 32'h08, {21'h0, id});
    push_op(1'b1, 32'h0C, {24'h0, (len > 8'd8) ? 8'd8 : len});
    push_op(1'b1, 32'h10, {24'h0, d0});
    push_op(1'b1, 32'h14, {24'h0, d1});
    push_op(1'b1, 32'h00, {30'h0, LB, 1'b1});
    if (tmo) begin
      for (int i = 0; i < PMAX; i++) push_op(1'b0, 32'h04, 32'h0);
      push_op(1'b1, 32'h04, 32'h7);
    end else begin
      push_op(1'b0, 32'h04, 32'h0);
      if (rx) begin
        push_op(1'b0, 32'h18, 32'h0);
        push_op(1'b0, 32'h1C, 32'h0);
        push_op(1'b0, 32'h20, 32'h0);
        push_op(1'b0, 32'h24, 32'h0);
        push_op(1'b1, 32'h04, 32'h3);
      end else begin
        push_op(1'b1, 32'h04, 32'h1);
      end
    end
  endtask

  task automatic set_req(input int i, input logic [10:0] id, input logic [7:0] len,
                         input logic [7:0] d0, input logic [7:0] d1);
    req_id[11*i +: 11] = id;
    req_len[8*i +: 8]  = len;
    req_d0[8*i +: 8]   = d0;
    req_d1[8*i +: 8]   = d1;
  endtask

  task automatic run_txn(input string name, input int lat, input logic [NREQ-1:0] oh,
                         input bit err, input bit rx, input logic [10:0] xid,
                         input logic [7:0] xlen, input logic [7:0] xd0, input logic [7:0] xd1,
                         input bit drop, output int e);
    int done_c, nrx;
    bit done;
    logic [NREQ-1:0] ackv, errv;
    logic [34:0] rxf;
    op_t x;
    e = -1; done = 0; done_c = 0; nrx = 0; ackv = '0; errv = '0; rxf = '0;
    for (int t = 0; t < 600 && !done; t++) begin
      @(negedge clk);
      if (busy && e < 0) e = cyc_cnt;
      if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s extra_op got we=%0b adr=%h dat=%h required none", name, wb_we_o, wb_adr_o, wb_dat_o);
        end else begin
          x = exp_q.pop_front();
          if (wb_we_o !== x.we || wb_adr_o !== x.adr || (x.we && wb_dat_o !== x.dat)) begin
            errors++;
            $display("FAIL %s bus_op got we=%0b adr=%h dat=%h required we=%0b adr=%h dat=%h",
                     name, wb_we_o, wb_adr_o, wb_dat_o, x.we, x.adr, x.dat);
          end
        end
      end
      if (rx_valid) begin
        nrx++;
        rxf = {rx_id, rx_len, rx_d0, rx_d1};
      end
      if (req_ack != '0 || req_err != '0) begin
        done = 1; done_c = cyc_cnt; ackv = req_ack; errv = req_err;
        if (drop) req_valid = req_valid & ~(req_ack | req_err);
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s completion got none required pulse within 600 cycles", name);
    end
    checks++;
    if (done_c - e != lat) begin
      errors++;
      $display("FAIL %s latency got %0d required %0d", name, done_c - e, lat);
    end
    checks++;
    if ((err ? errv : ackv) !== oh) begin
      errors++;
      $display("FAIL %s grant_pulse got %b required %b", name, err ? errv : ackv, oh);
    end
    checks++;
    if ((err ? ackv : errv) !== '0) begin
      errors++;
      $display("FAIL %s other_pulse got %b required 0", name, err ? ackv : errv);
    end
    checks++;
    if (nrx != (rx ? 1 : 0)) begin
      errors++;
      $display("FAIL %s rx_valid_count got %0d required %0d", name, nrx, rx ? 1 : 0);
    end
    if (rx) begin
      checks++;
      if (rxf !== {xid, xlen, xd0, xd1}) begin
        errors++;
        $display("FAIL %s rx_fields got %h required %h", name, rxf, {xid, xlen, xd0, xd1});
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s ops_left got %0d required 0", name, exp_q.size());
    end
    @(negedge clk);
    checks++;
    if ({busy, req_ack, req_err, rx_valid} !== '0) begin
      errors++;
      $display("FAIL %s after_done got busy=%0b ack=%b err=%b rxv=%0b required all 0",
               name, busy, req_ack, req_err, rx_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h required 0", all_out);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int e, e_prev;
    e_prev = -1;
    for (int i = 0; i < NREQ; i++) set_req(i, 11'h100 + 11'(i), 8'(i + 1), 8'h10 + 8'(i), 8'h20 + 8'(i));
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      int g;
      g = k % NREQ;
      push_txn(11'h100 + 11'(g), 8'(g + 1), 8'h10 + 8'(g), 8'h20 + 8'(g), 1'b1, 1'b0);
      run_txn("round_robin", 33, NREQ'(1) << g, 1'b0, 1'b1, 11'h100 + 11'(g), 8'(g + 1),
              8'h10 + 8'(g), 8'h20 + 8'(g), 1'b0, e);
      if (k == 7) req_valid = '0;
      if (e_prev >= 0) begin
        checks++;
        if (e - e_prev != 35) begin
          errors++;
          $display("FAIL back_to_back_spacing got %0d required 35", e - e_prev);
        end
      end
      e_prev = e;
    end
  endtask

  task automatic test_basic();
    int e;
    set_req(2, 11'h123, 8'd2, 8'hA5, 8'h5A);
    req_valid = 4'b0100;
    push_txn(11'h123, 8'd2, 8'hA5, 8'h5A, 1'b1, 1'b0);
    run_txn("basic", 33, 4'b0100, 1'b0, 1'b1, 11'h123, 8'd2, 8'hA5, 8'h5A, 1'b1, e);
    checks++;
    if (s_st !== 3'b000) begin
      errors++;
      $display("FAIL basic_status_after got %b required 000", s_st);
    end
  endtask

  task automatic test_len_clamp();
    int e;
    set_req(1, 11'h7FF, 8'd12, 8'hFF, 8'h00);
    req_valid = 4'b0010;
    push_txn(11'h7FF, 8'd12, 8'hFF, 8'h00, 1'b1, 1'b0);
    run_txn("len_clamp", 33, 4'b0010, 1'b0, 1'b1, 11'h7FF, 8'd8, 8'hFF, 8'h00, 1'b1, e);
  endtask

  task automatic test_no_rx();
    int e;
    mode_norx = 1;
    set_req(0, 11'h042, 8'd1, 8'h3C, 8'hC3);
    req_valid = 4'b0001;
    push_txn(11'h042, 8'd1, 8'h3C, 8'hC3, 1'b0, 1'b0);
    run_txn("no_rx", 21, 4'b0001, 1'b0, 1'b0, 11'h0, 8'h0, 8'h0, 8'h0, 1'b1, e);
    mode_norx = 0;
  endtask

  task automatic test_timeout();
    int e;
    mode_nodone = 1;
    set_req(3, 11'h555, 8'd4, 8'h11, 8'h22);
    req_valid = 4'b1000;
    push_txn(11'h555, 8'd4, 8'h11, 8'h22, 1'b0, 1'b1);
    run_txn("timeout", 3 * (5 + PMAX + 1), 4'b1000, 1'b1, 1'b0, 11'h0, 8'h0, 8'h0, 8'h0, 1'b1, e);
    mode_nodone = 0;
  endtask

  task automatic test_reset_mid();
    int e;
    bit hit;
    hit = 0;
    set_req(3, 11'h2AA, 8'd3, 8'h77, 8'h88);
    req_valid = 4'b1000;
    for (int t = 0; t < 200 && !hit; t++) begin
      @(negedge clk);
      if (wb_stb_o && wb_adr_o == 32'h10) hit = 1;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL reset_mid_reach_wr_d0 got none required WR_D0 op");
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs got %h required 0", all_out);
    end
    @(negedge clk);
    @(negedge clk);
    exp_q.delete();
    push_txn(11'h2AA, 8'd3, 8'h77, 8'h88, 1'b1, 1'b0);
    rst_n = 1'b1;
    run_txn("reset_mid_restart", 33, 4'b1000, 1'b0, 1'b1, 11'h2AA, 8'd3, 8'h77, 8'h88, 1'b1, e);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_basic();
    test_len_clamp();
    test_no_rx();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/can_tx_scheduler.md
# can_tx_scheduler

Wishbone master sequencer that shares one CAN register-shell controller among NREQ frame requesters. Round-robin arbitration picks a requester, then the block programs TX_ID/TX_LEN/TX_DATA0/TX_DATA1 and fires CMD.TX_START. It polls STATUS for TX_DONE, drains RX_* when RX_READY is set, and W1C-clears STATUS. It sits between application frame sources and the CAN controller's Wishbone slave port.

## Interface
- NREQ, 4: number of requesters (2..8)
- LOOPBACK, 1: value written to CMD bit1 on every start
- POLL_MAX, 255: STATUS reads without TX_DONE before timeout (1..255)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  per-requester frame pending
- req_id  in  11*NREQ  requester i ID at [11i+10:11i]
- req_len  in  8*NREQ  DLC, slice 8i
- req_d0, req_d1  in  8*NREQ each  data bytes, slice 8i
- req_ack  out  NREQ  one-cycle pulse to granted requester on success
- req_err  out  NREQ  one-cycle pulse to granted requester on poll timeout
- busy  out  1  high from grant until return to IDLE
- grant_idx  out  3  index of current/last grant
- rx_valid  out  1  one-cycle pulse, rx_* fields updated
- rx_id  out  11; rx_len  out  8; rx_d0, rx_d1  out  8  received frame
- wb_adr_o  out  32; wb_dat_o  out  32; wb_dat_i  in  32
- wb_we_o, wb_cyc_o, wb_stb_o  out  1; wb_ack_i  in  1

## Operation
- Register word addresses: CMD 0x00, STATUS 0x04, TX_ID 0x08, TX_LEN 0x0C, TX_DATA0 0x10, TX_DATA1 0x14, RX_ID 0x18, RX_LEN 0x1C, RX_DATA0 0x20, RX_DATA1 0x24.
- States: IDLE, WR_ID, WR_LEN, WR_D0, WR_D1, WR_CMD, POLL, RD_RID, RD_RLEN, RD_RD0, RD_RD1, CLR, DONE.
- IDLE: if any req_valid, grant first valid index at or after rr_ptr (wrapping). Capture that requester's id/len/d0/d1 into internal registers. Set rr_ptr = (winner+1) mod NREQ. Later req_valid/field changes are ignored until DONE.
- WR_LEN writes min(len,8). WR_D0/WR_D1 write the zero-extended byte. WR_CMD writes {30'b0, LOOPBACK, 1'b1}.
- POLL reads STATUS:
  - bit0=0: increment poll count and repeat. When the count reaches POLL_MAX, go to CLR with W1C value 0x7 and flag timeout.
  - bit0=1 and bit1=1: latch status, go to RD_RID.
  - bit0=1 and bit1=0: go to CLR with W1C value 0x1.
- RD_* states load rx_id=dat_i[10:0], rx_len=dat_i[7:0], rx_d0/rx_d1=dat_i[7:0]. After RD_RD1, go to CLR with W1C value 0x3.
- CLR writes the W1C value to STATUS.
- DONE pulses exactly one of req_ack[grant]/req_err[grant]. Pulses rx_valid if RX was drained. Returns to IDLE.

## Timing
- Bus op:
  - cyc/stb/we/adr/dat are registered and held until wb_ack_i is sampled high.
  - They are deasserted on that edge and stay low for exactly one gap cycle before the next op.
  - Against a zero-wait slave, each op is 2 active cycles + 1 gap.
  - No ack timeout: the block waits indefinitely for wb_ack_i.
- Read data is captured on the edge where wb_ack_i=1.
- Grant edge E (req_valid sampled in IDLE). Op n drives stb in cycles E+3n-2 and E+3n-1.
- With loopback RX, the sequence is 11 ops; the first POLL already sees TX_DONE.
  - req_ack/rx_valid are high in cycle E+33.
  - IDLE is active in E+34; the earliest next grant edge is the end of E+34.
- Without RX data the sequence is 7 ops: ack in cycle E+21.
- Timeout path: 5 + POLL_MAX + 1 ops, then req_err.
- Reset values: all outputs 0, rr_ptr=0, state IDLE, poll count 0.
- Reset mid-operation: the bus is released immediately (async); there is no partial pulse. Requesters re-present after reset.
- Simultaneous requests: the single grant follows rr_ptr. The others wait; no request is starved beyond NREQ-1 transactions.

## Test plan
- req_valid[2]=1, id 0x123, len 2, d0 0xA5, d1 0x5A, LOOPBACK=1 -> bus write sequence exactly as listed. rx_id=0x123, rx_len=2, rx_d0=0xA5, rx_d1=0x5A, rx_valid and req_ack[2] in E+33, STATUS reads 0 afterward.
- All four req_valid held high for 8 transactions -> grant order 0,1,2,3,0,1,2,3.
- len=12 -> TX_LEN written 8, rx_len=8.
- LOOPBACK=0 on the real controller -> 7 ops, CLR writes 0x1, req_ack in E+21, no rx_valid.
- Stub slave never sets TX_DONE, POLL_MAX=3 -> 3 STATUS reads, STATUS write 0x7, req_err pulse, no req_ack.
- rst_n low during WR_D0 -> cyc/stb low asynchronously, all outputs 0. After release, a new request starts with WR_ID and completes normally.
